// File: rtl/vid_testpattern_if.sv
// rtl/vid_testpattern_if.sv - video stream bundle (valid/ready/data/last/user)
interface vid_testpattern_if #(
    parameter int PW = 24
);
    logic          M_VID_VALID;
    logic          M_VID_READY;
    logic [PW-1:0] M_VID_DATA;
    logic          M_VID_LAST;
    logic          M_VID_USER;

    modport master (
        output M_VID_VALID,
        input  M_VID_READY,
        output M_VID_DATA,
        output M_VID_LAST,
        output M_VID_USER
    );

    modport slave (
        input  M_VID_VALID,
        output M_VID_READY,
        input  M_VID_DATA,
        input  M_VID_LAST,
        input  M_VID_USER
    );
endinterface

// File: rtl/vid_testpattern.sv
// rtl/vid_testpattern.sv - test-pattern video source (bars, solid, grey ramp, checkerboard)
module vid_testpattern #(
    parameter int LGDIM       = 11,
    parameter int PW          = 24,
    parameter int DEF_PATTERN = 0
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESETN,
    input  logic             i_en,
    input  logic [1:0]       i_pattern,
    input  logic [PW-1:0]    i_color,
    input  logic [LGDIM-1:0] i_width,
    input  logic [LGDIM-1:0] i_height,
    vid_testpattern_if.master m_vid,
    output logic             o_busy
);
    typedef enum logic {S_IDLE = 1'b0, S_FRAME = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [LGDIM-1:0] r_w, r_h, r_bw, r_x, r_y, r_bcnt;
    logic [LGDIM-1:0] w_w_nxt, w_h_nxt, w_bw_nxt, w_x_nxt, w_y_nxt, w_bcnt_nxt;
    logic [1:0]       r_pat, w_pat_nxt;
    logic [PW-1:0]    r_color, w_color_nxt;
    logic [2:0]       r_bar, w_bar_nxt;
    logic             r_valid, r_last, r_user;
    logic             w_valid_nxt, w_last_nxt, w_user_nxt;
    logic [PW-1:0]    r_data, w_data_nxt;

    logic             w_load, w_frame_end, w_relatch, w_hl, w_vl;
    logic [LGDIM-1:0] w_in_w, w_in_h, w_in_shr, w_in_bw;
    logic [LGDIM-1:0] w_eff_w, w_eff_h, w_eff_bw;
    logic [1:0]       w_eff_pat;
    logic [PW-1:0]    w_eff_color, w_pix;
    logic [23:0]      w_grey;

    function automatic logic [23:0] bar_color(input logic [2:0] b);
        case (b)
            3'd0:    bar_color = 24'hFFFFFF;
            3'd1:    bar_color = 24'hFFFF00;
            3'd2:    bar_color = 24'h00FFFF;
            3'd3:    bar_color = 24'h00FF00;
            3'd4:    bar_color = 24'hFF00FF;
            3'd5:    bar_color = 24'hFF0000;
            3'd6:    bar_color = 24'h0000FF;
            default: bar_color = 24'h000000;
        endcase
    endfunction

    assign w_load      = !r_valid || m_vid.M_VID_READY;
    assign w_frame_end = r_valid && r_last && m_vid.M_VID_READY;
    assign w_relatch   = (r_state == S_FRAME) && w_frame_end && i_en;

    assign w_in_w   = (i_width < LGDIM'(2)) ? LGDIM'(2) : i_width;
    assign w_in_h   = (i_height == '0) ? LGDIM'(1) : i_height;
    assign w_in_shr = w_in_w >> 3;
    assign w_in_bw  = (w_in_shr == '0) ? LGDIM'(1) : w_in_shr;

    // On a back-to-back frame the first pixel must already use the freshly latched settings.
    assign w_eff_w     = w_relatch ? w_in_w    : r_w;
    assign w_eff_h     = w_relatch ? w_in_h    : r_h;
    assign w_eff_bw    = w_relatch ? w_in_bw   : r_bw;
    assign w_eff_pat   = w_relatch ? i_pattern : r_pat;
    assign w_eff_color = w_relatch ? i_color   : r_color;

    assign w_hl   = (r_x == w_eff_w - LGDIM'(1));
    assign w_vl   = (r_y == w_eff_h - LGDIM'(1));
    assign w_grey = {r_x[7:0], r_x[7:0], r_x[7:0]};

    always_comb begin
        w_pix = '0;
        case (w_eff_pat)
            2'd0:    w_pix = PW'(bar_color(r_bar));
            2'd1:    w_pix = w_eff_color;
            2'd2:    w_pix = PW'(w_grey);
            default: w_pix = (r_x[4] ^ r_y[4]) ? PW'(24'hFFFFFF) : '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_w_nxt     = r_w;
        w_h_nxt     = r_h;
        w_bw_nxt    = r_bw;
        w_pat_nxt   = r_pat;
        w_color_nxt = r_color;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_bcnt_nxt  = r_bcnt;
        w_bar_nxt   = r_bar;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_last_nxt  = r_last;
        w_user_nxt  = r_user;
        case (r_state)
            S_IDLE: begin
                if (i_en) begin
                    w_state_nxt = S_FRAME;
                    w_w_nxt     = w_in_w;
                    w_h_nxt     = w_in_h;
                    w_bw_nxt    = w_in_bw;
                    w_pat_nxt   = i_pattern;
                    w_color_nxt = i_color;
                end
            end
            S_FRAME: begin
                if (w_load) begin
                    if (w_frame_end && !i_en) begin
                        w_state_nxt = S_IDLE;
                        w_valid_nxt = 1'b0;
                    end else begin
                        w_w_nxt     = w_eff_w;
                        w_h_nxt     = w_eff_h;
                        w_bw_nxt    = w_eff_bw;
                        w_pat_nxt   = w_eff_pat;
                        w_color_nxt = w_eff_color;
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = w_pix;
                        w_user_nxt  = w_hl;
                        w_last_nxt  = w_hl && w_vl;
                        if (w_hl) begin
                            w_x_nxt    = '0;
                            w_bcnt_nxt = '0;
                            w_bar_nxt  = '0;
                            w_y_nxt    = w_vl ? '0 : r_y + LGDIM'(1);
                        end else begin
                            w_x_nxt = r_x + LGDIM'(1);
                            if (r_bcnt == w_eff_bw - LGDIM'(1)) begin
                                w_bcnt_nxt = '0;
                                if (r_bar != 3'd7)
                                    w_bar_nxt = r_bar + 3'd1;
                            end else begin
                                w_bcnt_nxt = r_bcnt + LGDIM'(1);
                            end
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= S_IDLE;
            r_w     <= LGDIM'(2);
            r_h     <= LGDIM'(1);
            r_bw    <= LGDIM'(1);
            r_pat   <= 2'(DEF_PATTERN);
            r_color <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_bcnt  <= '0;
            r_bar   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_user  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_w     <= w_w_nxt;
            r_h     <= w_h_nxt;
            r_bw    <= w_bw_nxt;
            r_pat   <= w_pat_nxt;
            r_color <= w_color_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_bar   <= w_bar_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_last  <= w_last_nxt;
            r_user  <= w_user_nxt;
        end
    end

    assign m_vid.M_VID_VALID = r_valid;
    assign m_vid.M_VID_DATA  = r_data;
    assign m_vid.M_VID_LAST  = r_last;
    assign m_vid.M_VID_USER  = r_user;
    assign o_busy            = (r_state == S_FRAME);
endmodule

// File: tb/tb_vid_testpattern.sv
// tb/tb_vid_testpattern.sv - self-checking bench for vid_testpattern
module tb_vid_testpattern;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pat = 2'd0;
    logic [23:0] color = 24'h0;
    logic [10:0] width = 11'd16;
    logic [10:0] height = 11'd4;
    logic        busy;
    int          checks = 0;
    int          failures = 0;
    int          rcnt = 0;

    vid_testpattern_if #(.PW(24)) vif();

    vid_testpattern #(.LGDIM(11), .PW(24), .DEF_PATTERN(0)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .i_en          (en),
        .i_pattern     (pat),
        .i_color       (color),
        .i_width       (width),
        .i_height      (height),
        .m_vid         (vif),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] model_pix(input int p, input logic [23:0] c,
                                               input int w, input int x, input int y);
        logic [23:0] bars [8];
        logic [7:0]  g;
        int bw, b;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        bw = (w / 8 == 0) ? 1 : w / 8;
        b  = (x / bw > 7) ? 7 : x / bw;
        g  = x[7:0];
        case (p)
            0:       return bars[b];
            1:       return c;
            2:       return {g, g, g};
            default: return ((((x / 16) ^ (y / 16)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    task automatic do_reset();
        en = 1'b0;
        vif.M_VID_READY = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // mode 0: ready always; 1: 1-0-0 repeating; 2: random
    task automatic get_beat(input int mode, output bit got, output int waits,
                            output logic [23:0] d, output bit u, output bit l, output bit hok);
        logic [25:0] hold;
        bit holding;
        holding = 1'b0;
        hold = '0;
        got = 1'b0; waits = 0; d = '0; u = 1'b0; l = 1'b0; hok = 1'b1;
        while (!got && waits < 50) begin
            @(negedge clk);
            waits++;
            rcnt++;
            case (mode)
                0:       vif.M_VID_READY = 1'b1;
                1:       vif.M_VID_READY = (rcnt % 3 == 0);
                default: vif.M_VID_READY = 1'($urandom_range(0, 1));
            endcase
            if (vif.M_VID_VALID) begin
                if (holding && {vif.M_VID_DATA, vif.M_VID_USER, vif.M_VID_LAST} !== hold)
                    hok = 1'b0;
                if (vif.M_VID_READY) begin
                    got = 1'b1;
                    d = vif.M_VID_DATA; u = vif.M_VID_USER; l = vif.M_VID_LAST;
                end else begin
                    holding = 1'b1;
                    hold = {vif.M_VID_DATA, vif.M_VID_USER, vif.M_VID_LAST};
                end
            end else begin
                if (holding) hok = 1'b0;
                holding = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({vif.M_VID_VALID, vif.M_VID_DATA, vif.M_VID_LAST, vif.M_VID_USER, busy} !== 28'h0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b data=%h last=%b user=%b busy=%b required all 0",
                     vif.M_VID_VALID, vif.M_VID_DATA, vif.M_VID_LAST, vif.M_VID_USER, busy);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (vif.M_VID_VALID !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_en: got valid=%b busy=%b required 0 0", vif.M_VID_VALID, busy);
        end
    endtask

    task automatic test_bars();
        bit got, u, l, hok; int waits; logic [23:0] d, e;
        do_reset();
        width = 16; height = 4; pat = 0; en = 1'b1;
        for (int b = 0; b < 128; b++) begin
            get_beat(0, got, waits, d, u, l, hok);
            e = model_pix(0, 24'h0, 16, b % 16, (b / 16) % 4);
            checks++;
            if (!got || d !== e || u !== (b % 16 == 15) || l !== (b % 64 == 63)) begin
                failures++;
                $display("FAIL bars beat %0d: got data=%h user=%b last=%b required data=%h user=%b last=%b",
                         b, d, u, l, e, (b % 16 == 15), (b % 64 == 63));
            end
            checks++;
            if (waits != ((b == 0) ? 2 : 1)) begin
                failures++;
                $display("FAIL bars_timing beat %0d: got %0d cycles required %0d", b, waits, (b == 0) ? 2 : 1);
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL bars_busy: got %b required 1", busy);
        end
    endtask

    task automatic test_backpressure();
        bit got, u, l, hok; int waits; logic [23:0] d, e;
        do_reset();
        width = 16; height = 4; pat = 0; en = 1'b1;
        for (int b = 0; b < 80; b++) begin
            get_beat(1, got, waits, d, u, l, hok);
            e = model_pix(0, 24'h0, 16, b % 16, (b / 16) % 4);
            checks++;
            if (!got || !hok || d !== e || u !== (b % 16 == 15) || l !== (b % 64 == 63)) begin
                failures++;
                $display("FAIL backpressure beat %0d: got data=%h user=%b last=%b stable=%b required data=%h user=%b last=%b stable=1",
                         b, d, u, l, hok, e, (b % 16 == 15), (b % 64 == 63));
            end
        end
    endtask

    task automatic test_midframe_change();
        bit got, u, l, hok; int waits, c, w, x, y, p; logic [23:0] d, e; bit eu, el;
        do_reset();
        width = 16; height = 4; pat = 0; color = 24'hABCDEF; en = 1'b1;
        for (int b = 0; b < 192; b++) begin
            get_beat(0, got, waits, d, u, l, hok);
            if (b == 20) begin
                width = 32; pat = 1; color = 24'h123456;
            end
            c = (b < 64) ? b : b - 64;
            w = (b < 64) ? 16 : 32;
            p = (b < 64) ? 0 : 1;
            x = c % w; y = c / w;
            e = model_pix(p, 24'h123456, w, x, y);
            eu = (x == w - 1); el = eu && (y == 3);
            checks++;
            if (!got || d !== e || u !== eu || l !== el) begin
                failures++;
                $display("FAIL midframe beat %0d: got data=%h user=%b last=%b required data=%h user=%b last=%b",
                         b, d, u, l, e, eu, el);
            end
        end
    endtask

    task automatic test_en_drop();
        bit got, u, l, hok; int waits; logic [23:0] d, e;
        do_reset();
        width = 16; height = 4; pat = 3; en = 1'b1;
        for (int b = 0; b < 64; b++) begin
            get_beat(0, got, waits, d, u, l, hok);
            if (b == 10) en = 1'b0;
            e = model_pix(3, 24'h0, 16, b % 16, b / 16);
            checks++;
            if (!got || d !== e || l !== (b == 63)) begin
                failures++;
                $display("FAIL en_drop beat %0d: got data=%h last=%b required data=%h last=%b", b, d, l, e, (b == 63));
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (vif.M_VID_VALID !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL en_drop_idle cycle %0d: got valid=%b busy=%b required 0 0", i, vif.M_VID_VALID, busy);
            end
        end
        pat = 0; en = 1'b1;
        get_beat(0, got, waits, d, u, l, hok);
        checks++;
        if (!got || waits != 2 || d !== 24'hFFFFFF || u !== 1'b0 || l !== 1'b0) begin
            failures++;
            $display("FAIL en_restart: got cycles=%0d data=%h user=%b last=%b required cycles=2 data=ffffff user=0 last=0",
                     waits, d, u, l);
        end
    endtask

    task automatic test_clamp();
        bit got, u, l, hok; int waits; logic [23:0] d, e;
        do_reset();
        width = 1; height = 0; pat = 2; en = 1'b1;
        for (int b = 0; b < 6; b++) begin
            get_beat(2, got, waits, d, u, l, hok);
            e = model_pix(2, 24'h0, 2, b % 2, 0);
            checks++;
            if (!got || !hok || d !== e || u !== (b % 2 == 1) || l !== (b % 2 == 1)) begin
                failures++;
                $display("FAIL clamp beat %0d: got data=%h user=%b last=%b required data=%h user=%b last=%b",
                         b, d, u, l, e, (b % 2 == 1), (b % 2 == 1));
            end
        end
    endtask

    task automatic test_async_reset();
        bit got, u, l, hok; int waits; logic [23:0] d, e;
        do_reset();
        width = 16; height = 4; pat = 0; en = 1'b1;
        for (int b = 0; b < 30; b++) get_beat(0, got, waits, d, u, l, hok);
        @(negedge clk);
        vif.M_VID_READY = 1'b0;
        checks++;
        if (vif.M_VID_VALID !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset: got valid=%b busy=%b required 1 1", vif.M_VID_VALID, busy);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({vif.M_VID_VALID, vif.M_VID_DATA, vif.M_VID_LAST, vif.M_VID_USER, busy} !== 28'h0) begin
            failures++;
            $display("FAIL async_reset: got valid=%b data=%h last=%b user=%b busy=%b required all 0",
                     vif.M_VID_VALID, vif.M_VID_DATA, vif.M_VID_LAST, vif.M_VID_USER, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 0; b < 64; b++) begin
            get_beat(0, got, waits, d, u, l, hok);
            e = model_pix(0, 24'h0, 16, b % 16, b / 16);
            checks++;
            if (!got || d !== e || u !== (b % 16 == 15) || l !== (b == 63) || (b == 0 && waits != 2)) begin
                failures++;
                $display("FAIL post_reset beat %0d: got data=%h user=%b last=%b cycles=%0d required data=%h user=%b last=%b",
                         b, d, u, l, waits, e, (b % 16 == 15), (b == 63));
            end
        end
    endtask

    task automatic test_random();
        bit got, u, l, hok; int waits, fw, fh, fp; logic [23:0] d, e, fc; bit eu, el;
        do_reset();
        width = 11'($urandom_range(0, 40)); height = 11'($urandom_range(0, 5));
        pat = 2'($urandom_range(0, 3)); color = 24'($urandom); en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            fw = (width < 2) ? 2 : int'(width);
            fh = (height < 1) ? 1 : int'(height);
            fp = int'(pat); fc = color;
            for (int b = 0; b < fw * fh; b++) begin
                get_beat(2, got, waits, d, u, l, hok);
                if (b == 2 && fw * fh > 3) begin
                    width = 11'($urandom_range(0, 40)); height = 11'($urandom_range(0, 5));
                    pat = 2'($urandom_range(0, 3)); color = 24'($urandom);
                end
                e = model_pix(fp, fc, fw, b % fw, b / fw);
                eu = (b % fw == fw - 1); el = (b == fw * fh - 1);
                checks++;
                if (!got || !hok || d !== e || u !== eu || l !== el) begin
                    failures++;
                    $display("FAIL random f%0d beat %0d (%0dx%0d p%0d): got data=%h user=%b last=%b stable=%b required data=%h user=%b last=%b",
                             f, b, fw, fh, fp, d, u, l, hok, e, eu, el);
                end
            end
        end
    endtask

    initial begin
        vif.M_VID_READY = 1'b1;
        test_reset();
        test_bars();
        test_backpressure();
        test_midframe_change();
        test_en_drop();
        test_clamp();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
